stopwatch_ctrl: RTL and testbench

Front-end controller for the stopwatch counter chain. It turns the raw start/stop, lap and clear buttons into a run/pause/lap state machine. It generates the base count-enable tick that feeds the least-significant counter_flop stage, a synchronous clear for the whole chain, and a display-freeze strobe for lap hold. It sits between the board buttons and the first counter_flop instance.

---
 rtl/stopwatch_pkg.sv | 16 +
 rtl/stopwatch_ctrl_if.sv | 23 ++
 rtl/btn_debounce.sv | 42 ++++
 rtl/stopwatch_ctrl.sv | 113 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants and state encoding for the stopwatch front-end controller.
package stopwatch_pkg;

    localparam int unsigned DEF_TICK_DIV        = 100000;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
    localparam int unsigned PRESC_W             = 20;
    localparam int unsigned DEB_W               = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_LAP     = 2'b11
    } state_t;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and counter-chain control outputs of the stopwatch controller.
interface stopwatch_ctrl_if;

    logic       btn_start_stop;
    logic       btn_lap;
    logic       btn_clear;
    logic       tick_out;
    logic       counter_clr;
    logic       freeze;
    logic       running;
    logic [1:0] state_out;

    modport master (
        output btn_start_stop, btn_lap, btn_clear,
        input  tick_out, counter_clr, freeze, running, state_out
    );

    modport slave (
        input  btn_start_stop, btn_lap, btn_clear,
        output tick_out, counter_clr, freeze, running, state_out
    );

endinterface

// File: rtl/btn_debounce.sv
// Synchronise and debounce one raw button; emit a single pulse per accepted press.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic level_out,
    output logic press_out
);

    logic             sync1;
    logic             sync2;
    logic [DEB_W-1:0] cnt;

    // Level flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            cnt       <= '0;
            level_out <= 1'b0;
            press_out <= 1'b0;
        end else begin
            sync1     <= raw_in;
            sync2     <= sync1;
            press_out <= 1'b0;
            if (sync2 == level_out) begin
                cnt <= '0;
            end else if (cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt       <= '0;
                level_out <= sync2;
                press_out <= sync2;
            end else begin
                cnt <= cnt + DEB_W'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap controller: debounced buttons, base-tick prescaler and counter-chain control.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV        = DEF_TICK_DIV,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    stopwatch_ctrl_if.slave  bus
);

    logic [2:0]         level_unused;
    logic               press_ss;
    logic               press_lap;
    logic               press_clr;
    logic               ss_c;
    logic               lap_c;
    logic               clr_c;
    state_t             state;
    state_t             state_nxt;
    logic [PRESC_W-1:0] presc;
    logic               tick_q;
    logic               clr_q;
    logic               freeze_q;
    logic               run_q;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_ss (
        .clk(clk), .rst(rst), .raw_in(bus.btn_start_stop),
        .level_out(level_unused[0]), .press_out(press_ss)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_lap (
        .clk(clk), .rst(rst), .raw_in(bus.btn_lap),
        .level_out(level_unused[1]), .press_out(press_lap)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clr (
        .clk(clk), .rst(rst), .raw_in(bus.btn_clear),
        .level_out(level_unused[2]), .press_out(press_clr)
    );

    // Same-cycle presses: clear beats start/stop beats lap; losers are dropped.
    assign ss_c  = press_ss & ~press_clr;
    assign lap_c = press_lap & ~press_ss & ~press_clr;

    always_comb begin
        state_nxt = state;
        clr_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (press_clr)  clr_c     = 1'b1;
                else if (ss_c)  state_nxt = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (ss_c)       state_nxt = ST_PAUSED;
                else if (lap_c) state_nxt = ST_LAP;
            end
            ST_PAUSED: begin
                if (press_clr) begin
                    clr_c     = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (ss_c) begin
                    state_nxt = ST_RUNNING;
                end
            end
            ST_LAP: begin
                if (ss_c)       state_nxt = ST_PAUSED;
                else if (lap_c) state_nxt = ST_RUNNING;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Prescaler follows the pre-transition state so a stop on terminal count still ticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            presc    <= '0;
            tick_q   <= 1'b0;
            clr_q    <= 1'b0;
            freeze_q <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            clr_q    <= clr_c;
            freeze_q <= (state_nxt == ST_LAP);
            run_q    <= (state_nxt == ST_RUNNING) || (state_nxt == ST_LAP);
            tick_q   <= 1'b0;
            case (state)
                ST_RUNNING, ST_LAP: begin
                    if (presc == PRESC_W'(TICK_DIV - 1)) begin
                        presc  <= '0;
                        tick_q <= 1'b1;
                    end else begin
                        presc <= presc + PRESC_W'(1);
                    end
                end
                ST_PAUSED: begin
                    if (clr_c) presc <= '0;
                end
                default: presc <= '0;
            endcase
        end
    end

    assign bus.tick_out    = tick_q;
    assign bus.counter_clr = clr_q;
    assign bus.freeze      = freeze_q;
    assign bus.running     = run_q;
    assign bus.state_out   = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed, table-driven bench for stopwatch_ctrl with TICK_DIV=10, DEBOUNCE_CYCLES=4.
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   tick_cnt;
    int   clr_cnt;

    stopwatch_ctrl_if bus ();

    stopwatch_ctrl #(.TICK_DIV(10), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ss;
        logic       lap;
        logic       clr;
        int         cycles;
        logic [1:0] st;
        logic       frz;
        logic       run;
        int         ticks;
        int         clrs;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Advance n clock cycles, sampling on the falling edge and counting pulses.
    task automatic run_cycles(input int n);
        tick_cnt = 0;
        clr_cnt  = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.tick_out)    tick_cnt++;
            if (bus.counter_clr) clr_cnt++;
        end
    endtask

    task automatic set_btn(input logic ss, input logic lap, input logic clr);
        bus.btn_start_stop = ss;
        bus.btn_lap        = lap;
        bus.btn_clear      = clr;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_state"}, int'(bus.state_out), 0);
        check({tag, "_running"}, int'(bus.running), 0);
        check({tag, "_freeze"}, int'(bus.freeze), 0);
        check({tag, "_tick"}, int'(bus.tick_out), 0);
        check({tag, "_clr"}, int'(bus.counter_clr), 0);
    endtask

    initial begin
        //         ss lap clr cyc  state  frz run ticks clrs
        vecs[0]  = '{1'b1, 1'b0, 1'b0,   6, 2'b00, 1'b0, 1'b0,  0, 0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0,   1, 2'b01, 1'b0, 1'b1,  0, 0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0,  13, 2'b01, 1'b0, 1'b1,  1, 0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 100, 2'b01, 1'b0, 1'b1, 10, 0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0,   7, 2'b11, 1'b1, 1'b1,  1, 0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0,  13, 2'b11, 1'b1, 1'b1,  1, 0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0,   7, 2'b01, 1'b0, 1'b1,  1, 0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0,   7, 2'b10, 1'b0, 1'b0,  0, 0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0,  30, 2'b10, 1'b0, 1'b0,  0, 0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0,   7, 2'b01, 1'b0, 1'b1,  0, 0};
        vecs[10] = '{1'b0, 1'b0, 1'b0,   5, 2'b01, 1'b0, 1'b1,  1, 0};
        vecs[11] = '{1'b0, 1'b0, 1'b1,   7, 2'b01, 1'b0, 1'b1,  0, 0};
        vecs[12] = '{1'b1, 1'b0, 1'b0,   7, 2'b10, 1'b0, 1'b0,  1, 0};
        vecs[13] = '{1'b0, 1'b0, 1'b1,   7, 2'b00, 1'b0, 1'b0,  0, 1};
        vecs[14] = '{1'b0, 1'b0, 1'b0,   5, 2'b00, 1'b0, 1'b0,  0, 0};
        vecs[15] = '{1'b1, 1'b0, 1'b0,   7, 2'b01, 1'b0, 1'b1,  0, 0};
        vecs[16] = '{1'b0, 1'b0, 1'b0,  10, 2'b01, 1'b0, 1'b1,  1, 0};

        rst = 1'b0;
        set_btn(1'b0, 1'b0, 1'b0);
        run_cycles(3);
        check_idle_outputs("reset");
        rst = 1'b1;

        for (int v = 0; v < 17; v++) begin
            set_btn(vecs[v].ss, vecs[v].lap, vecs[v].clr);
            run_cycles(vecs[v].cycles);
            check($sformatf("v%0d_state", v), int'(bus.state_out), int'(vecs[v].st));
            check($sformatf("v%0d_freeze", v), int'(bus.freeze), int'(vecs[v].frz));
            check($sformatf("v%0d_running", v), int'(bus.running), int'(vecs[v].run));
            check($sformatf("v%0d_ticks", v), tick_cnt, vecs[v].ticks);
            check($sformatf("v%0d_clrs", v), clr_cnt, vecs[v].clrs);
        end

        // Lap glitch of 3 cycles while running must not register.
        set_btn(1'b0, 1'b1, 1'b0);
        run_cycles(3);
        set_btn(1'b0, 1'b0, 1'b0);
        run_cycles(10);
        check("glitch_state", int'(bus.state_out), 1);
        check("glitch_freeze", int'(bus.freeze), 0);

        // Stop lands on the terminal count: tick still issued, prescaler then holds at 0.
        set_btn(1'b1, 1'b0, 1'b0);
        run_cycles(7);
        check("stop_tc_ticks", tick_cnt, 1);
        check("stop_tc_state", int'(bus.state_out), 2);
        set_btn(1'b0, 1'b0, 1'b0);
        run_cycles(20);
        check("stop_tc_hold_ticks", tick_cnt, 0);
        set_btn(1'b1, 1'b0, 1'b0);
        run_cycles(7);
        check("resume_state", int'(bus.state_out), 1);
        check("resume_ticks", tick_cnt, 0);
        set_btn(1'b0, 1'b0, 1'b0);
        run_cycles(9);
        check("resume_9_ticks", tick_cnt, 0);
        run_cycles(1);
        check("resume_10_ticks", tick_cnt, 1);

        // Start/stop and clear accepted in the same cycle while paused: clear wins.
        set_btn(1'b1, 1'b0, 1'b0);
        run_cycles(7);
        check("pause_state", int'(bus.state_out), 2);
        set_btn(1'b0, 1'b0, 1'b0);
        run_cycles(10);
        set_btn(1'b1, 1'b0, 1'b1);
        run_cycles(7);
        check("simul_state", int'(bus.state_out), 0);
        check("simul_clr_now", int'(bus.counter_clr), 1);
        check("simul_clrs", clr_cnt, 1);
        run_cycles(1);
        check("simul_clr_after", int'(bus.counter_clr), 0);
        check("simul_state_after", int'(bus.state_out), 0);

        // Asynchronous reset while running.
        set_btn(1'b0, 1'b0, 1'b0);
        run_cycles(10);
        set_btn(1'b1, 1'b0, 1'b0);
        run_cycles(7);
        check("pre_rst_state", int'(bus.state_out), 1);
        set_btn(1'b0, 1'b0, 1'b0);
        run_cycles(5);
        rst = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        run_cycles(2);
        rst = 1'b1;
        run_cycles(10);
        check("post_rst_ticks", tick_cnt, 0);
        check("post_rst_clrs", clr_cnt, 0);
        check("post_rst_state", int'(bus.state_out), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
